// File: rtl/ifft_cp_insert_if.sv
// Sample-stream bundle between the IFFT core, the cyclic-prefix stage and the interpolator.
// Input handshake: a sample transfers on a rising edge where in_valid=1 and in_ready=1.
// Output stream has no back-pressure. Downstream takes every out_valid=1 sample.
interface ifft_cp_insert_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_real;
    logic [DATA_WIDTH-1:0] in_imag;
    logic                  in_ready;
    logic                  drop_err;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_real;
    logic [DATA_WIDTH-1:0] out_imag;
    logic                  sym_start;
    logic                  sym_end;

    modport master (
        output in_valid, in_real, in_imag,
        input  in_ready, drop_err, out_valid, out_real, out_imag, sym_start, sym_end
    );

    modport slave (
        input  in_valid, in_real, in_imag,
        output in_ready, drop_err, out_valid, out_real, out_imag, sym_start, sym_end
    );
endinterface

// File: rtl/ifft_cp_insert.sv
// Cyclic-prefix insertion: buffers one N-sample IFFT symbol, then emits the last CP_LEN
// samples followed by the whole symbol as one gap-free burst.
module ifft_cp_insert #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 16,
    parameter int CP_LEN     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ifft_cp_insert_if.slave      bus,
    output logic [1:0]           dbg_state
);
    localparam int AW    = (N > 1) ? $clog2(N) : 1;
    localparam int BURST = N + CP_LEN;
    localparam int RW    = $clog2(BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                state;
    logic [AW-1:0]         wr_cnt;
    logic [RW-1:0]         rd_cnt;
    logic [AW-1:0]         rd_addr;
    logic                  accept;
    logic [DATA_WIDTH-1:0] buf_re [N];
    logic [DATA_WIDTH-1:0] buf_im [N];

    assign accept    = bus.in_valid & bus.in_ready;
    assign dbg_state = state;

    // The prefix reads the tail of the symbol first. Then the read wraps to index 0.
    always_comb begin
        rd_addr = '0;
        if (rd_cnt < RW'(CP_LEN))
            rd_addr = AW'(rd_cnt + RW'(N - CP_LEN));
        else
            rd_addr = AW'(rd_cnt - RW'(CP_LEN));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_re[wr_cnt] <= bus.in_real;
            buf_im[wr_cnt] <= bus.in_imag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            bus.in_ready  <= 1'b1;
            bus.drop_err  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_real  <= '0;
            bus.out_imag  <= '0;
            bus.sym_start <= 1'b0;
            bus.sym_end   <= 1'b0;
        end else begin
            bus.drop_err  <= bus.in_valid & ~bus.in_ready;
            bus.out_valid <= 1'b0;
            bus.out_real  <= '0;
            bus.out_imag  <= '0;
            bus.sym_start <= 1'b0;
            bus.sym_end   <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        if (wr_cnt == AW'(N - 1)) begin
                            state        <= EMIT;
                            wr_cnt       <= '0;
                            rd_cnt       <= '0;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state  <= FILL;
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    bus.out_valid <= 1'b1;
                    bus.out_real  <= buf_re[rd_addr];
                    bus.out_imag  <= buf_im[rd_addr];
                    bus.sym_start <= (rd_cnt == '0);
                    bus.sym_end   <= (rd_cnt == RW'(BURST - 1));
                    // The last read has now been issued, so the buffer can take the next symbol.
                    if (rd_cnt == RW'(BURST - 1)) begin
                        state        <= IDLE;
                        rd_cnt       <= '0;
                        bus.in_ready <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
